// File: rtl/zap_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zap_ram_pkg
// Description : Shared definitions for the byte-enabled pipelined RAM request
//               master: RAM read latency and the request record layout.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package zap_ram_pkg;

  // Cycles from read-address capture to valid data on the RAM read port.
  localparam int RAM_RD_LAT = 3;

  // Default geometry used by the request record.
  localparam int REQ_WIDTH = 32;
  localparam int REQ_DEPTH = 32;

  // One request beat: non-zero ben is a write, all-zero ben is a read.
  typedef struct packed {
    logic [REQ_WIDTH/8-1:0]         ben;
    logic [$clog2(REQ_DEPTH)-1:0]   addr;
    logic [REQ_WIDTH-1:0]           wdata;
  } req_t;

endpackage : zap_ram_pkg
`default_nettype wire

// File: rtl/zap_ram_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : zap_ram_req_fifo
// Description : Synchronous response FIFO, WIDTH x DEPTH. Head entry is read
//               straight from the storage flops. Push and pop may occur in the
//               same cycle, including when full.
// Ports       : clk_i, rst_i (sync, active-high)
//               push_i/data_i   - write side
//               pop_i/data_o    - read side (data_o = head entry)
//               empty_o, full_o, count_o - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module zap_ram_req_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    // When full, a simultaneous pop frees the head slot being written.
    do_push  = push_i & (~full_o | do_pop);
    // DEPTH is a power of two, so pointers wrap naturally.
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Storage cleared so the head reads zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule : zap_ram_req_fifo
`default_nettype wire

// File: rtl/zap_ram_ben_req.sv
`default_nettype none
// ============================================================================
// Module      : zap_ram_ben_req
// Description : Request-side master for a 3-cycle-latency byte-enabled
//               pipelined RAM. Accepts byte-masked writes and full-word reads,
//               drives the RAM clock-enable/write/read ports, tracks in-flight
//               reads with a latency-matched valid pipe and returns read data
//               in order through a credit-protected response FIFO.
// Ports       : i_clk, i_reset (sync, active-high)
//               i_req_valid/o_req_ready, i_req_ben, i_req_addr, i_req_wdata
//               o_rsp_valid/i_rsp_ready, o_rsp_data
//               o_ram_clken, o_ram_wr_en, o_ram_wr_data, o_ram_wr_addr,
//               o_ram_rd_addr, i_ram_rd_data
// Options     : ZAP_RAM_REQ_ASSERT_EN - compiles in simulation assertions.
// Revision    : 1.0 - initial release
// ============================================================================
module zap_ram_ben_req
  import zap_ram_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [WIDTH/8-1:0]       i_req_ben,
  input  logic [$clog2(DEPTH)-1:0] i_req_addr,
  input  logic [WIDTH-1:0]         i_req_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [WIDTH-1:0]         o_rsp_data,
  output logic                     o_ram_clken,
  output logic [WIDTH/8-1:0]       o_ram_wr_en,
  output logic [WIDTH-1:0]         o_ram_wr_data,
  output logic [$clog2(DEPTH)-1:0] o_ram_wr_addr,
  output logic [$clog2(DEPTH)-1:0] o_ram_rd_addr,
  input  logic [WIDTH-1:0]         i_ram_rd_data
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic                  w_is_write;
  logic                  w_fire;
  logic                  w_rd_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_unused;

  logic [RAM_RD_LAT-1:0] v_q, v_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign w_is_write = |i_req_ben;

  // Writes never consume a credit; reads need a reserved FIFO slot.
  assign o_req_ready = ~i_reset & (w_is_write | (cnt_q < CW'(FIFO_DEPTH)));
  assign w_fire      = i_req_valid & o_req_ready;
  assign w_rd_fire   = w_fire & ~w_is_write;

  // Both RAM addresses follow the request bus; only wr_en qualifies a write.
  assign o_ram_wr_addr = i_req_addr;
  assign o_ram_rd_addr = i_req_addr;
  assign o_ram_wr_data = i_req_wdata;
  assign o_ram_wr_en   = (w_fire && w_is_write) ? i_req_ben : '0;

  // The RAM only needs to advance while a new request or a read that has
  // not yet reached the last RAM stage exists.
  assign o_ram_clken = ~i_reset & (w_fire | (|v_q[RAM_RD_LAT-2:0]));

  // Last stage of the valid pipe marks i_ram_rd_data as valid this cycle.
  assign w_push      = v_q[RAM_RD_LAT-1];
  assign o_rsp_valid = ~w_fifo_empty & ~i_reset;
  assign w_pop       = o_rsp_valid & i_rsp_ready;

  always_comb begin
    v_d   = {v_q[RAM_RD_LAT-2:0], w_rd_fire};
    cnt_d = cnt_q;
    if (w_rd_fire && !w_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!w_rd_fire && w_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  zap_ram_req_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (w_push),
    .data_i  (i_ram_rd_data),
    .pop_i   (w_pop),
    .data_o  (o_rsp_data),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full),
    .count_o (w_fifo_count)
  );

  // FIFO status is redundant with the credit counter in normal operation.
  assign w_unused = ^{w_fifo_full, w_fifo_count};

`ifdef ZAP_RAM_REQ_ASSERT_EN
  logic                     stall_q;
  logic [WIDTH/8-1:0]       prev_ben_q;
  logic [$clog2(DEPTH)-1:0] prev_addr_q;
  logic [WIDTH-1:0]         prev_wdata_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= i_req_valid & ~o_req_ready;
    end
    prev_ben_q   <= i_req_ben;
    prev_addr_q  <= i_req_addr;
    prev_wdata_q <= i_req_wdata;
  end

  always @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(w_push && w_fifo_full && !w_pop))
        else $fatal(1, "zap_ram_ben_req: response FIFO push while full");
      assert (!(i_rsp_ready && o_rsp_valid && w_fifo_empty))
        else $fatal(1, "zap_ram_ben_req: response FIFO pop while empty");
      assert (!(cnt_q == CW'(FIFO_DEPTH) && w_rd_fire && !w_pop))
        else $fatal(1, "zap_ram_ben_req: credit counter overflow");
      assert (!(cnt_q == '0 && w_pop && !w_rd_fire))
        else $fatal(1, "zap_ram_ben_req: credit counter underflow");
      assert (!$isunknown(i_req_valid))
        else $fatal(1, "zap_ram_ben_req: i_req_valid is X");
      assert (!$isunknown(i_rsp_ready))
        else $fatal(1, "zap_ram_ben_req: i_rsp_ready is X");
      if (stall_q && i_req_valid) begin
        assert ({i_req_ben, i_req_addr, i_req_wdata} ==
                {prev_ben_q, prev_addr_q, prev_wdata_q})
          else $fatal(1, "zap_ram_ben_req: request changed while stalled");
      end
    end
  end
`endif

endmodule : zap_ram_ben_req
`default_nettype wire
